cpu_control_unit: RTL
=====================

// Module: cpu_control_unit
// PURPOSE
//  Multi-cycle sequencer for the 4-bit CPU. Fetches 8-bit instructions from program ROM,
//  decodes them, drives the combinational ALU (a, b, alu_sel), and writes the result back.
//  Owns PC, IR, the accumulator (ACC) and the Z/C flag registers; the ALU lives outside.
// PARAMETERS
//  PC_W      4     program-counter width (ROM depth = 2**PC_W)
//  RESET_PC  0     PC value loaded on reset
// PORTS
//  clk          in   1     system clock, rising edge
//  rst_n        in   1     asynchronous active-low reset
//  run          in   1     1 = sequence; 0 = stall in FETCH, no state change
//  instr        in   8     ROM data at address pc (combinational ROM); [7:4] opcode, [3:0] operand
//  alu_result   in   4     ALU result
//  alu_carry    in   1     ALU carry/borrow
//  alu_zero     in   1     ALU zero flag
//  pc           out  PC_W  program counter / ROM address
//  alu_a        out  4     = ACC
//  alu_b        out  4     = IR[3:0]
//  alu_sel      out  3     000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR
//  acc          out  4     accumulator
//  flag_z       out  1     latched zero flag
//  flag_c       out  1     latched carry flag
//  instr_done   out  1     1-cycle pulse in the WRITEBACK cycle of each retired instruction
//  halted       out  1     1 while in HALT
// BEHAVIOUR
//  Reset (async, rst_n=0): state=FETCH, pc=RESET_PC, IR=0, acc=0, flag_z=0, flag_c=0,
//   alu_sel=000, instr_done=0, halted=0. Effect is immediate, including mid-instruction.
//  FSM: FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH; HLT goes WRITEBACK -> HALT.
//   FETCH: if run=1, IR<=instr, go DECODE; if run=0, stay, all registers hold.
//   DECODE: alu_sel registered from IR opcode (unused opcodes: 000).
//   EXECUTE: ALU settles; no register updates. run is ignored outside FETCH.
//   WRITEBACK: update per opcode, pulse instr_done, pc update.
//   HALT: absorbing; only reset leaves it. pc, acc and flags hold.
//  Latency: exactly 4 clocks per instruction when run=1; instr_done every 4th cycle.
//  ISA (opcode: WRITEBACK effect):
//   0 NOP; 1 LDI: acc<=imm, flags hold; 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR:
//   acc<=alu_result, flag_z<=alu_zero, flag_c<=alu_carry (logic ops latch the ALU carry as given);
//   7 JMP: pc<=imm; 8 JZ: pc<=imm if flag_z else pc+1; 9 JC: pc<=imm if flag_c else pc+1;
//   F HLT; A-E reserved: treated as NOP.
//  PC: pc+1 for all non-taken/non-jump opcodes, wrapping modulo 2**PC_W (15 -> 0 at PC_W=4).
//   HLT does not increment pc. Jump targets are imm zero-extended to PC_W.
//  JZ/JC test the flags latched before this instruction (no same-cycle forwarding).
//  alu_a/alu_b are stable from DECODE through WRITEBACK; the ALU is combinational, so
//   alu_result is sampled in WRITEBACK only.
//  pc is constant from FETCH through EXECUTE, so instr is stable while IR is loaded.
// TESTING
//  1. Reset: drop rst_n mid-EXECUTE -> pc=0, acc=0, flags=0, state FETCH in the same cycle.
//  2. LDI 3; ADD 2 -> acc=5, Z=0, C=0; instr_done pulses at cycles 4 and 8.
//  3. LDI 15; ADD 1 -> acc=0, Z=1, C=1; then JZ 6 -> pc=6; JC 9 -> pc=9.
//  4. LDI 5; SUB 5 -> acc=0, Z=1; JZ not taken after LDI 1; ADD 1 (Z=0) -> pc increments.
//  5. JMP at pc=15 with imm=0, and NOP at pc=15 -> pc=0 in both cases (wrap).
//  6. run=0 for 5 cycles in FETCH -> no IR/pc change; HLT -> halted=1, pc held; reset clears it.

Source files
------------

// File: rtl/cpu_control_unit_if.sv
// cpu_control_unit_if: bus between the CPU sequencer, the program ROM and the external ALU.
//
// Signals
//   pc          sequencer -> ROM   program counter / ROM address
//   instr       ROM -> sequencer   combinational ROM data at pc ([7:4] opcode, [3:0] operand)
//   alu_a       sequencer -> ALU   operand A (accumulator)
//   alu_b       sequencer -> ALU   operand B (instruction immediate)
//   alu_sel     sequencer -> ALU   000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR
//   alu_result  ALU -> sequencer   4-bit result
//   alu_carry   ALU -> sequencer   carry (ADD) / borrow (SUB)
//   alu_zero    ALU -> sequencer   result == 0
//
// Modports
//   master  the sequencer (cpu_control_unit)
//   slave   the ROM/ALU side
interface cpu_control_unit_if #(
  parameter int unsigned PC_W = 4
) ();

  logic [PC_W-1:0] pc;
  logic [7:0]      instr;
  logic [3:0]      alu_a;
  logic [3:0]      alu_b;
  logic [2:0]      alu_sel;
  logic [3:0]      alu_result;
  logic            alu_carry;
  logic            alu_zero;

  modport master (
    output pc,
    output alu_a,
    output alu_b,
    output alu_sel,
    input  instr,
    input  alu_result,
    input  alu_carry,
    input  alu_zero
  );

  modport slave (
    input  pc,
    input  alu_a,
    input  alu_b,
    input  alu_sel,
    output instr,
    output alu_result,
    output alu_carry,
    output alu_zero
  );

endinterface

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle sequencer for the 4-bit CPU.
//
// Fetches 8-bit instructions from a combinational program ROM, decodes them, drives the
// external combinational ALU and writes results back. Owns PC, IR, ACC and the Z/C flags.
// Every instruction takes exactly four cycles: FETCH -> DECODE -> EXECUTE -> WRITEBACK.
// HLT retires through WRITEBACK and then parks in HALT until reset.
//
// Parameters
//   PC_W      program-counter width (ROM depth 2**PC_W)
//   RESET_PC  PC value loaded on reset
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   run         1 = sequence; 0 = stall in FETCH with all state held
//   bus         ROM/ALU bus (master side): pc, instr, alu_a/b/sel, alu_result/carry/zero
//   acc         accumulator
//   flag_z      latched zero flag
//   flag_c      latched carry flag
//   instr_done  high for the WRITEBACK cycle of each retired instruction
//   halted      high while in HALT
module cpu_control_unit #(
  parameter int unsigned PC_W     = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  cpu_control_unit_if.master     bus,
  output logic [3:0]             acc,
  output logic                   flag_z,
  output logic                   flag_c,
  output logic                   instr_done,
  output logic                   halted
);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StWriteback,
    StHalt
  } state_e;

  typedef enum logic [3:0] {
    OpNop = 4'h0,
    OpLdi = 4'h1,
    OpAdd = 4'h2,
    OpSub = 4'h3,
    OpAnd = 4'h4,
    OpOr  = 4'h5,
    OpXor = 4'h6,
    OpJmp = 4'h7,
    OpJz  = 4'h8,
    OpJc  = 4'h9,
    OpHlt = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluXor = 3'b100
  } alu_sel_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [3:0]      acc_q, acc_d;
  logic            flag_z_q, flag_z_d;
  logic            flag_c_q, flag_c_d;
  logic [2:0]      alu_sel_q, alu_sel_d;

  logic [3:0]      opcode;
  logic [3:0]      imm;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] jump_target;

  assign opcode      = ir_q[7:4];
  assign imm         = ir_q[3:0];
  // Natural-width add wraps modulo 2**PC_W.
  assign pc_inc      = pc_q + PC_W'(1);
  assign jump_target = PC_W'(imm);

  // Opcodes that do not use the ALU select ADD so the ALU inputs stay benign.
  function automatic logic [2:0] alu_sel_of(input logic [3:0] op);
    logic [2:0] sel;
    sel = AluAdd;
    case (op)
      OpAdd:   sel = AluAdd;
      OpSub:   sel = AluSub;
      OpAnd:   sel = AluAnd;
      OpOr:    sel = AluOr;
      OpXor:   sel = AluXor;
      default: sel = AluAdd;
    endcase
    return sel;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      pc_q      <= PC_W'(RESET_PC);
      ir_q      <= '0;
      acc_q     <= '0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      alu_sel_q <= AluAdd;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      acc_q     <= acc_d;
      flag_z_q  <= flag_z_d;
      flag_c_q  <= flag_c_d;
      alu_sel_q <= alu_sel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    acc_d     = acc_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    alu_sel_d = alu_sel_q;

    unique case (state_q)
      StFetch: begin
        // pc is held through EXECUTE, so instr is still the word at pc here.
        if (run) begin
          ir_d    = bus.instr;
          state_d = StDecode;
        end
      end

      StDecode: begin
        alu_sel_d = alu_sel_of(opcode);
        state_d   = StExecute;
      end

      // ALU settles on the registered operands; nothing is committed.
      StExecute: begin
        state_d = StWriteback;
      end

      StWriteback: begin
        pc_d    = pc_inc;
        state_d = StFetch;
        case (opcode)
          OpLdi: acc_d = imm;
          OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
            acc_d    = bus.alu_result;
            flag_z_d = bus.alu_zero;
            flag_c_d = bus.alu_carry;
          end
          OpJmp: pc_d = jump_target;
          // Branches see the flags committed by earlier instructions only.
          OpJz:  if (flag_z_q) pc_d = jump_target;
          OpJc:  if (flag_c_q) pc_d = jump_target;
          OpHlt: begin
            pc_d    = pc_q;
            state_d = StHalt;
          end
          default: ; // NOP and reserved opcodes: pc advance only
        endcase
      end

      StHalt: begin
        state_d = StHalt;
      end

      default: begin
        state_d = StFetch;
      end
    endcase
  end

  assign bus.pc      = pc_q;
  assign bus.alu_a   = acc_q;
  assign bus.alu_b   = imm;
  assign bus.alu_sel = alu_sel_q;

  assign acc        = acc_q;
  assign flag_z     = flag_z_q;
  assign flag_c     = flag_c_q;
  assign instr_done = (state_q == StWriteback);
  assign halted     = (state_q == StHalt);

endmodule
